// File: rtl/vram_rect_filler.sv
// -----------------------------------------------------------------------------
// vram_rect_filler
//   Write-side companion of the VGA scan-out path. Accepts one rectangle-fill
//   command over a valid/ready handshake, clips it to the framebuffer, then
//   issues one VRAM write per pixel in row-major order, honouring write stalls.
//
// Ports
//   clock_25mhz   in   sole clock, rising edge
//   reset         in   asynchronous, active-high reset
//   cmd_valid     in   command present
//   cmd_ready     out  block can accept a command (registered)
//   cmd_x/cmd_y   in   top-left corner of the rectangle
//   cmd_w/cmd_h   in   rectangle size in pixels
//   cmd_color     in   fill pixel value
//   vram_we       out  write strobe (registered)
//   vram_addr     out  write address = y*FB_WIDTH + x (registered)
//   vram_data_in  out  write data (registered)
//   vram_wr_ready in   VRAM accepts the write this cycle
//   busy          out  command in progress (registered)
//   done          out  one-cycle pulse when a command completes (registered)
// -----------------------------------------------------------------------------
module vram_rect_filler #(
  parameter int FB_WIDTH    = 160,
  parameter int FB_HEIGHT   = 120,
  parameter int ADDR_WIDTH  = 15,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                   clock_25mhz,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_x,
  input  logic [6:0]             cmd_y,
  input  logic [7:0]             cmd_w,
  input  logic [6:0]             cmd_h,
  input  logic [PIXEL_WIDTH-1:0] cmd_color,
  output logic                   vram_we,
  output logic [ADDR_WIDTH-1:0]  vram_addr,
  output logic [PIXEL_WIDTH-1:0] vram_data_in,
  input  logic                   vram_wr_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLIP,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [8:0]            FB_W9  = 9'(FB_WIDTH);
  localparam logic [8:0]            FB_H9  = 9'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] FB_W_A = ADDR_WIDTH'(FB_WIDTH);

  state_t                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   vram_we_q, vram_we_d;
  logic [ADDR_WIDTH-1:0]  vram_addr_q, vram_addr_d;
  logic [PIXEL_WIDTH-1:0] vram_data_q, vram_data_d;

  // Captured command
  logic [7:0]             x_q, x_d;
  logic [6:0]             y_q, y_d;
  logic [7:0]             w_q, w_d;
  logic [6:0]             h_q, h_d;
  logic [PIXEL_WIDTH-1:0] color_q, color_d;

  // Clipped size and fill walk
  logic [8:0]             wc_q, wc_d;
  logic [8:0]             hc_q, hc_d;
  logic [8:0]             col_q, col_d;
  logic [8:0]             row_q, row_d;
  logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;

  // Clip arithmetic on the captured command, 9 bits wide so FB_WIDTH - x
  // cannot wrap for any legal x.
  logic [8:0] x9, y9, w9, h9, rem_w, rem_h, clip_w, clip_h;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    x9     = {1'b0, x_q};
    y9     = {2'b00, y_q};
    w9     = {1'b0, w_q};
    h9     = {2'b00, h_q};
    rem_w  = FB_W9 - x9;
    rem_h  = FB_H9 - y9;
    clip_w = 9'd0;
    clip_h = 9'd0;
    if (x9 < FB_W9 && w_q != 8'd0) begin
      clip_w = (w9 < rem_w) ? w9 : rem_w;
    end
    if (y9 < FB_H9 && h_q != 7'd0) begin
      clip_h = (h9 < rem_h) ? h9 : rem_h;
    end
  end

  logic last_col, last_row;
  assign last_col = (col_q == wc_q - 9'd1);
  assign last_row = (row_q == hc_q - 9'd1);

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    vram_we_d   = vram_we_q;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    wc_d        = wc_q;
    hc_d        = hc_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;

    unique case (state_q)
      S_IDLE: begin
        // cmd_ready comes up one edge after reset release and stays up here.
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          x_d         = cmd_x;
          y_d         = cmd_y;
          w_d         = cmd_w;
          h_d         = cmd_h;
          color_d     = cmd_color;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_CLIP;
        end
      end

      S_CLIP: begin
        wc_d = clip_w;
        hc_d = clip_h;
        if (clip_w == 9'd0 || clip_h == 9'd0) begin
          state_d = S_DONE;
        end else begin
          // The only multiply; rows after the first are reached by adding
          // FB_WIDTH in FILL.
          row_base_d = ADDR_WIDTH'(y_q) * FB_W_A;
          col_d      = 9'd0;
          row_d      = 9'd0;
          state_d    = S_FILL;
        end
      end

      S_FILL: begin
        if (!vram_we_q) begin
          // First cycle in FILL: present the first pixel.
          vram_we_d   = 1'b1;
          vram_addr_d = row_base_q + ADDR_WIDTH'(x_q);
          vram_data_d = color_q;
        end else if (vram_wr_ready) begin
          if (last_col) begin
            if (last_row) begin
              vram_we_d = 1'b0;
              state_d   = S_DONE;
            end else begin
              col_d       = 9'd0;
              row_d       = row_q + 9'd1;
              row_base_d  = row_base_q + FB_W_A;
              vram_addr_d = row_base_q + FB_W_A + ADDR_WIDTH'(x_q);
            end
          end else begin
            // Same row: row_base + x + (col+1) is simply the next address.
            col_d       = col_q + 9'd1;
            vram_addr_d = vram_addr_q + ADDR_WIDTH'(1);
          end
        end
        // With vram_wr_ready low everything holds: the stall case.
      end

      S_DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock_25mhz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      wc_q        <= '0;
      hc_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      wc_q        <= wc_d;
      hc_q        <= hc_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign vram_we      = vram_we_q;
  assign vram_addr    = vram_addr_q;
  assign vram_data_in = vram_data_q;

endmodule

// File: tb/tb_vram_rect_filler.sv
// Directed bench for vram_rect_filler: basic fill, full clear, clipping,
// write stalls, back-to-back handshake and reset in the middle of a fill.
module tb_vram_rect_filler;

  logic        clock_25mhz = 1'b0;
  logic        reset       = 1'b0;
  logic        cmd_valid   = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x       = '0;
  logic [6:0]  cmd_y       = '0;
  logic [7:0]  cmd_w       = '0;
  logic [6:0]  cmd_h       = '0;
  logic [7:0]  cmd_color   = '0;
  logic        vram_we;
  logic [14:0] vram_addr;
  logic [7:0]  vram_data_in;
  logic        vram_wr_ready = 1'b1;
  logic        busy;
  logic        done;

  vram_rect_filler dut (
    .clock_25mhz  (clock_25mhz),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .vram_we      (vram_we),
    .vram_addr    (vram_addr),
    .vram_data_in (vram_data_in),
    .vram_wr_ready(vram_wr_ready),
    .busy         (busy),
    .done         (done)
  );

  always #20 clock_25mhz = ~clock_25mhz;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Write monitor: records every accepted write, counts done pulses,
  // out-of-range addresses and any change of the write port during a stall.
  int unsigned wr_addr[$];
  logic [7:0]  wr_data[$];
  int unsigned exp_addr[$];
  logic [7:0]  exp_data[$];
  int          done_cnt  = 0;
  int          hold_err  = 0;
  int          oob_cnt   = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [14:0] prev_addr;
  logic [7:0]  prev_data;
  logic [3:0]  stall_pat = 4'b1001;

  always @(posedge clock_25mhz) begin
    if (prev_stall && (vram_we !== 1'b1 || vram_addr !== prev_addr ||
                       vram_data_in !== prev_data)) begin
      hold_err++;
    end
    prev_stall = vram_we && !vram_wr_ready && !reset;
    if (prev_stall) stall_cnt++;
    prev_addr = vram_addr;
    prev_data = vram_data_in;
    if (vram_we && vram_wr_ready && !reset) begin
      wr_addr.push_back(int'(vram_addr));
      wr_data.push_back(vram_data_in);
      if (vram_addr >= 15'd19200) oob_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic add_rect(input int x, input int y, input int wc, input int hc,
                          input logic [7:0] c);
    for (int r = 0; r < hc; r++) begin
      for (int k = 0; k < wc; k++) begin
        exp_addr.push_back(int'((y + r) * 160 + x + k));
        exp_data.push_back(c);
      end
    end
  endtask

  task automatic clear_exp();
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic compare_writes(input string tag);
    int ae = 0;
    int de = 0;
    int n;
    check({tag, "_nwrites"}, wr_addr.size(), exp_addr.size());
    n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      if (wr_addr[i] != exp_addr[i]) ae++;
      if (wr_data[i] != exp_data[i]) de++;
    end
    check({tag, "_addr_errs"}, ae, 0);
    check({tag, "_data_errs"}, de, 0);
  endtask

  // Called at a negedge. Index j counts negedges after the accept edge N
  // (j=0 is the one right after N), so j marks values launched by edge N+j.
  task automatic do_cmd(input string tag, input logic [7:0] x, input logic [6:0] y,
                        input logic [7:0] w, input logic [6:0] h, input logic [7:0] c,
                        input bit stall, output int lat, output int first_we);
    bit acc = 1'b0;
    lat      = -1;
    first_we = -1;
    wr_addr.delete();
    wr_data.delete();
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      else @(negedge clock_25mhz);
    end
    check({tag, "_accepted"}, acc, 1);
    @(posedge clock_25mhz);
    @(negedge clock_25mhz);
    cmd_valid = 1'b0;
    for (int j = 0; j < 30000 && lat < 0; j++) begin
      if (j > 0) @(negedge clock_25mhz);
      vram_wr_ready = stall ? stall_pat[j % 4] : 1'b1;
      if (vram_we && first_we < 0) first_we = j;
      if (done) lat = j;
    end
    vram_wr_ready = 1'b1;
    check({tag, "_done_seen"}, (lat >= 0), 1);
  endtask

  task automatic run_case(input string tag, input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] w, input logic [6:0] h, input logic [7:0] c,
                          input bit stall, input int exp_lat, input int exp_fwe);
    int lat, fwe, d0;
    d0 = done_cnt;
    do_cmd(tag, x, y, w, h, c, stall, lat, fwe);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_first_we"}, fwe, exp_fwe);
    @(negedge clock_25mhz);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    compare_writes(tag);
  endtask

  task automatic expect_case1();
    clear_exp();
    exp_addr = '{810, 811, 812, 970, 971, 972};
    for (int i = 0; i < 6; i++) exp_data.push_back(8'hE0);
  endtask

  initial begin
    int  d0;
    int  n_before;
    bit  acc_b;

    // Reset state
    #2 reset = 1'b1;
    repeat (3) @(negedge clock_25mhz);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_vram_we", vram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_vram_data", vram_data_in, 0);
    reset = 1'b0;
    @(negedge clock_25mhz);
    check("rst_ready_after_release", cmd_ready, 1);

    // Basic 3x2 fill: first we at N+2, last write at N+8, done at N+9
    expect_case1();
    run_case("basic", 8'd10, 7'd5, 8'd3, 7'd2, 8'hE0, 1'b0, 9, 2);

    // Full clear: 19200 writes, done at N+3+19200
    clear_exp();
    add_rect(0, 0, 160, 120, 8'h00);
    run_case("clear", 8'd0, 7'd0, 8'd160, 7'd120, 8'h00, 1'b0, 19203, 2);
    check("clear_last_addr",
          (wr_addr.size() > 0) ? longint'(wr_addr[wr_addr.size() - 1]) : -1, 19199);

    // Clipping: bottom-right corner clips to 2x2
    clear_exp();
    add_rect(158, 118, 2, 2, 8'h3C);
    run_case("clip_corner", 8'd158, 7'd118, 8'd10, 7'd10, 8'h3C, 1'b0, 7, 2);

    // Fully off-screen in x, zero width, off-screen in y: no writes, done at N+2
    clear_exp();
    run_case("clip_x_off", 8'd200, 7'd0, 8'd5, 7'd3, 8'h11, 1'b0, 2, -1);
    run_case("w_zero", 8'd0, 7'd0, 8'd0, 7'd5, 8'h22, 1'b0, 2, -1);
    run_case("clip_y_off", 8'd0, 7'd120, 8'd4, 7'd4, 8'h33, 1'b0, 2, -1);

    // Maximum w/h on the last row: clips to 160x1
    clear_exp();
    add_rect(0, 119, 160, 1, 8'hA5);
    run_case("last_row", 8'd0, 7'd119, 8'd255, 7'd127, 8'hA5, 1'b0, 163, 2);

    // Stalls with ready pattern 1,0,0,1
    expect_case1();
    run_case("stall", 8'd10, 7'd5, 8'd3, 7'd2, 8'hE0, 1'b1, -1, 2);
    check("stall_seen", (stall_cnt > 0), 1);
    check("stall_hold_errs", hold_err, 0);

    // Handshake: valid stays high with changing payload during a fill;
    // the second command takes the payload present when cmd_ready is 1.
    wr_addr.delete();
    wr_data.delete();
    d0 = done_cnt;
    cmd_x = 8'd10; cmd_y = 7'd5; cmd_w = 8'd3; cmd_h = 7'd2; cmd_color = 8'hE0;
    cmd_valid = 1'b1;
    @(posedge clock_25mhz);
    acc_b = 1'b0;
    for (int j = 0; j < 200 && !acc_b; j++) begin
      @(negedge clock_25mhz);
      if (cmd_ready) begin
        cmd_x = 8'd0; cmd_y = 7'd1; cmd_w = 8'd2; cmd_h = 7'd1; cmd_color = 8'h5A;
        acc_b = 1'b1;
      end else begin
        cmd_x = 8'(j * 7 + 20); cmd_y = 7'(j + 3); cmd_w = 8'd4; cmd_h = 7'd3;
        cmd_color = 8'(j);
      end
    end
    check("hs_second_ready", acc_b, 1);
    @(posedge clock_25mhz);
    @(negedge clock_25mhz);
    cmd_valid = 1'b0;
    for (int j = 0; j < 200 && done_cnt < d0 + 2; j++) @(negedge clock_25mhz);
    repeat (3) @(negedge clock_25mhz);
    check("hs_done_pulses", done_cnt - d0, 2);
    clear_exp();
    add_rect(10, 5, 3, 2, 8'hE0);
    add_rect(0, 1, 2, 1, 8'h5A);
    compare_writes("hs");

    // Reset in the middle of a full clear
    wr_addr.delete();
    wr_data.delete();
    cmd_x = 8'd0; cmd_y = 7'd0; cmd_w = 8'd160; cmd_h = 7'd120; cmd_color = 8'h77;
    cmd_valid = 1'b1;
    @(posedge clock_25mhz);
    @(negedge clock_25mhz);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clock_25mhz);
    n_before = wr_addr.size();
    check("mid_nwrites_before", n_before, 48);
    check("mid_we_before", vram_we, 1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("mid_we_async", vram_we, 0);
    check("mid_busy_async", busy, 0);
    repeat (3) @(negedge clock_25mhz);
    check("mid_ready_in_reset", cmd_ready, 0);
    reset = 1'b0;
    @(negedge clock_25mhz);
    check("mid_ready_after", cmd_ready, 1);
    repeat (5) @(negedge clock_25mhz);
    check("mid_no_more_writes", wr_addr.size(), n_before);
    check("mid_no_done", done_cnt - d0, 0);

    expect_case1();
    run_case("post_reset", 8'd10, 7'd5, 8'd3, 7'd2, 8'hE0, 1'b0, 9, 2);

    check("oob_writes", oob_cnt, 0);
    check("hold_errs_total", hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
